// File: rtl/alu_reg_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: FSM encoding and the bit layout of the
// packed FIFO command word {ra, rb, rd, op, wb}.
package alu_reg_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRead = 3'd1,
    StExec = 3'd2,
    StWb   = 3'd3,
    StDone = 3'd4
  } seq_state_e;

  localparam int unsigned WbBit = 0;
  localparam int unsigned OpLsb = 1;

  function automatic int unsigned rd_lsb(input int unsigned op_w);
    return 1 + op_w;
  endfunction

  function automatic int unsigned rb_lsb(input int unsigned addr_w, input int unsigned op_w);
    return 1 + op_w + addr_w;
  endfunction

  function automatic int unsigned ra_lsb(input int unsigned addr_w, input int unsigned op_w);
    return 1 + op_w + 2 * addr_w;
  endfunction

  function automatic int unsigned cmd_width(input int unsigned addr_w, input int unsigned op_w);
    return 3 * addr_w + op_w + 1;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; pushes while full and pops while empty are
// dropped. Depth must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/alu_reg_sequencer.sv
// Command sequencer for the ALU/register-file datapath: queues commands and steps each one
// through read, execute, write-back and respond with one-cycle strobes.
module alu_reg_sequencer
  import alu_reg_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_W-1:0]      cmd_ra,
  input  logic [ADDR_W-1:0]      cmd_rb,
  input  logic [ADDR_W-1:0]      cmd_rd,
  input  logic [OP_W-1:0]        cmd_op,
  input  logic                   cmd_wb,
  output logic [ADDR_W-1:0]      dp_r_addr_a,
  output logic [ADDR_W-1:0]      dp_r_addr_b,
  output logic [ADDR_W-1:0]      dp_w_addr,
  output logic [OP_W-1:0]        dp_alu_op,
  output logic                   dp_alu_en,
  output logic                   dp_w_en,
  input  logic [DATA_W-1:0]      dp_res,
  input  logic [3:0]             dp_flags,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_res,
  output logic [3:0]             rsp_flags,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int unsigned CmdW  = cmd_width(ADDR_W, OP_W);
  localparam int unsigned RdLsb = rd_lsb(OP_W);
  localparam int unsigned RbLsb = rb_lsb(ADDR_W, OP_W);
  localparam int unsigned RaLsb = ra_lsb(ADDR_W, OP_W);

  seq_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
  logic [OP_W-1:0]         op_q, op_d;
  logic                    wb_q, wb_d;
  logic [DATA_W-1:0]       res_q, res_d;
  logic [3:0]              flags_q, flags_d;
  logic                    fifo_full, fifo_empty, fifo_pop;
  logic [CmdW-1:0]         fifo_wdata, fifo_rdata;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    alu_en, w_en, rsp_v;

  assign fifo_wdata = {cmd_ra, cmd_rb, cmd_rd, cmd_op, cmd_wb};

  alu_cmd_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(CmdW)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (cmd_valid),
    .wdata_i(fifo_wdata),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rd_d     = rd_q;
    op_d     = op_q;
    wb_d     = wb_q;
    res_d    = res_q;
    flags_d  = flags_q;
    fifo_pop = 1'b0;
    alu_en   = 1'b0;
    w_en     = 1'b0;
    rsp_v    = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          ra_d     = fifo_rdata[RaLsb +: ADDR_W];
          rb_d     = fifo_rdata[RbLsb +: ADDR_W];
          rd_d     = fifo_rdata[RdLsb +: ADDR_W];
          op_d     = fifo_rdata[OpLsb +: OP_W];
          wb_d     = fifo_rdata[WbBit];
          state_d  = StRead;
        end
      end
      StRead: state_d = StExec;
      StExec: begin
        alu_en  = 1'b1;
        state_d = StWb;
      end
      StWb: begin
        // Register 0 is hardwired, so its write strobe is never raised.
        w_en    = wb_q && (rd_q != '0);
        res_d   = dp_res;
        flags_d = dp_flags;
        state_d = StDone;
      end
      StDone: begin
        rsp_v   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      op_q    <= '0;
      wb_q    <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      op_q    <= op_d;
      wb_q    <= wb_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  // Outputs read as their reset values while rst is high, so an abort never leaks a strobe.
  assign cmd_ready   = rst | ~fifo_full;
  assign busy        = ~rst & ((state_q != StIdle) | ~fifo_empty);
  assign q_count     = rst ? '0 : fifo_count;
  assign dp_r_addr_a = rst ? '0 : ra_q;
  assign dp_r_addr_b = rst ? '0 : rb_q;
  assign dp_w_addr   = rst ? '0 : rd_q;
  assign dp_alu_op   = rst ? '0 : op_q;
  assign dp_alu_en   = ~rst & alu_en;
  assign dp_w_en     = ~rst & w_en;
  assign rsp_valid   = ~rst & rsp_v;
  assign rsp_res     = rst ? '0 : res_q;
  assign rsp_flags   = rst ? '0 : flags_q;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Self-checking bench: datapath stub, architectural reference model with scoreboard,
// table-driven vectors, directed corner cases and a randomized phase.
module tb_alu_reg_sequencer;
  localparam int unsigned DEPTH = 4;
  localparam int OpAdd = 0, OpSub = 1, OpAnd = 2, OpOr = 3, OpXor = 4, OpSll = 5;

  typedef struct packed {
    logic [4:0] ra;
    logic [4:0] rb;
    logic [4:0] rd;
    logic [3:0] op;
    logic       wb;
  } cmd_t;

  typedef struct {
    cmd_t        c;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        wen;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_ra = '0, cmd_rb = '0, cmd_rd = '0;
  logic [3:0]  cmd_op = '0;
  logic        cmd_wb = 1'b0;
  logic [4:0]  dp_r_addr_a, dp_r_addr_b, dp_w_addr;
  logic [3:0]  dp_alu_op;
  logic        dp_alu_en, dp_w_en;
  logic [31:0] dp_res;
  logic [3:0]  dp_flags;
  logic        rsp_valid;
  logic [31:0] rsp_res;
  logic [3:0]  rsp_flags;
  logic        busy;
  logic [2:0]  q_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_reg_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(5), .OP_W(4), .DATA_W(32)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_op(cmd_op), .cmd_wb(cmd_wb),
    .dp_r_addr_a(dp_r_addr_a), .dp_r_addr_b(dp_r_addr_b), .dp_w_addr(dp_w_addr),
    .dp_alu_op(dp_alu_op), .dp_alu_en(dp_alu_en), .dp_w_en(dp_w_en),
    .dp_res(dp_res), .dp_flags(dp_flags), .rsp_valid(rsp_valid), .rsp_res(rsp_res),
    .rsp_flags(rsp_flags), .busy(busy), .q_count(q_count)
  );

  // Returns {n, z, c, v, result}.
  function automatic logic [35:0] alu(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op[2:0])
      3'd0: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: r = a >> b[4:0];
      default: r = {31'd0, $signed(a) < $signed(b)};
    endcase
    return {r[31], r == 32'd0, c, v, r};
  endfunction

  function automatic cmd_t mk(input int ra, input int rb, input int rd, input int op,
                              input int wb);
    cmd_t c;
    c.ra = 5'(ra); c.rb = 5'(rb); c.rd = 5'(rd); c.op = 4'(op); c.wb = 1'(wb);
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Datapath stub: register file plus result latch, driven only by the DUT strobes.
  logic [31:0] init_rf [32];
  logic [31:0] dp_rf [32];
  logic [31:0] alu_q;
  logic [3:0]  flg_q;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) dp_rf[i] <= init_rf[i];
      alu_q <= '0;
      flg_q <= '0;
    end else begin
      if (dp_alu_en) {flg_q, alu_q} <= alu(dp_alu_op, dp_rf[dp_r_addr_a], dp_rf[dp_r_addr_b]);
      if (dp_w_en) dp_rf[dp_w_addr] <= alu_q;
    end
  end
  assign dp_res   = alu_q;
  assign dp_flags = flg_q;

  // Reference model: in-order command queue over an architectural register file.
  cmd_t        exp_q[$];
  logic [31:0] ref_rf [32];
  logic        saw_wen = 1'b0;
  int          rsp_seen = 0;
  int          wen_seen = 0;
  cmd_t        mh;
  logic [35:0] mr;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) ref_rf[i] = init_rf[i];
      saw_wen = 1'b0;
    end else begin
      if (dp_w_en) begin
        wen_seen++;
        saw_wen = 1'b1;
        if (exp_q.size() == 0) begin
          chk("wen_has_cmd", 64'(0), 64'(1));
        end else begin
          chk("wen_addr", 64'(dp_w_addr), 64'(exp_q[0].rd));
          chk("wen_allowed", 64'(1), 64'(exp_q[0].wb && exp_q[0].rd != 5'd0));
        end
      end
      if (rsp_valid) begin
        rsp_seen++;
        if (exp_q.size() == 0) begin
          chk("rsp_has_cmd", 64'(0), 64'(1));
        end else begin
          mh = exp_q.pop_front();
          mr = alu(mh.op, ref_rf[mh.ra], ref_rf[mh.rb]);
          chk("rsp_res", 64'(rsp_res), 64'(mr[31:0]));
          chk("rsp_flags", 64'(rsp_flags), 64'(mr[35:32]));
          chk("rsp_wen", 64'(saw_wen), 64'(mh.wb && mh.rd != 5'd0));
          if (mh.wb && mh.rd != 5'd0) ref_rf[mh.rd] = mr[31:0];
        end
        saw_wen = 1'b0;
      end
      if (cmd_valid && cmd_ready) exp_q.push_back({cmd_ra, cmd_rb, cmd_rd, cmd_op, cmd_wb});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input cmd_t c, input logic v);
    cmd_valid = v; cmd_ra = c.ra; cmd_rb = c.rb; cmd_rd = c.rd; cmd_op = c.op; cmd_wb = c.wb;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic run_one(input cmd_t c, output int t_alu, output int t_wen, output int t_rsp,
                         output logic [4:0] wa, output logic [31:0] res,
                         output logic [3:0] fl, output logic bz);
    t_alu = -1; t_wen = -1; t_rsp = -1; wa = '0; res = '0; fl = '0;
    drive(c, 1'b1);
    for (int k = 1; k <= 20 && t_rsp < 0; k++) begin
      step();
      if (k == 1) cmd_valid = 1'b0;
      if (dp_alu_en && t_alu < 0) t_alu = k;
      if (dp_w_en && t_wen < 0) begin t_wen = k; wa = dp_w_addr; end
      if (rsp_valid) begin t_rsp = k; res = rsp_res; fl = rsp_flags; end
    end
    step();
    bz = busy;
  endtask

  task automatic run_pair(input cmd_t a, input cmd_t b, input int gap, output int t0,
                          output int t1, output logic [31:0] r0, output logic [31:0] r1,
                          output int nw, output int nr, output int qc1, output int qc2);
    nr = 0; nw = 0; t0 = -1; t1 = -1; r0 = '0; r1 = '0; qc1 = -1; qc2 = -1;
    drive(a, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == gap) drive(b, 1'b1);
      else cmd_valid = 1'b0;
      if (k == 1) qc1 = int'(q_count);
      if (k == 2) qc2 = int'(q_count);
      if (dp_w_en) nw++;
      if (rsp_valid) begin
        if (nr == 0) begin t0 = k; r0 = rsp_res; end
        else if (nr == 1) begin t1 = k; r1 = rsp_res; end
        nr++;
      end
    end
    cmd_valid = 1'b0;
  endtask

  vec_t        vecs [10];
  cmd_t        fcmds [6];
  int          ta, tw, tr, t0, t1, nw, nr, qc1, qc2, idx, first_full, maxq, base_r, base_w;
  logic        bz, ready_at_full;
  logic [4:0]  wa;
  logic [31:0] res, r0, r1;
  logic [3:0]  fl;

  initial begin
    vecs[0] = '{mk(1, 2, 3, OpAdd, 1), 32'd12, 4'b0000, 1'b1};
    vecs[1] = '{mk(3, 1, 4, OpAdd, 1), 32'd17, 4'b0000, 1'b1};
    vecs[2] = '{mk(1, 2, 0, OpSub, 1), 32'hFFFF_FFFE, 4'b1000, 1'b0};
    vecs[3] = '{mk(2, 2, 5, OpXor, 0), 32'd0, 4'b0100, 1'b0};
    vecs[4] = '{mk(4, 3, 6, OpSub, 1), 32'd5, 4'b0010, 1'b1};
    vecs[5] = '{mk(6, 1, 7, OpSub, 1), 32'd0, 4'b0110, 1'b1};
    vecs[6] = '{mk(5, 1, 8, OpOr, 1), 32'd5, 4'b0000, 1'b1};
    vecs[7] = '{mk(0, 1, 9, OpAdd, 1), 32'd5, 4'b0000, 1'b1};
    vecs[8] = '{mk(5, 1, 10, OpAnd, 1), 32'd0, 4'b0100, 1'b1};
    vecs[9] = '{mk(1, 2, 11, OpSll, 1), 32'd640, 4'b0000, 1'b1};
    for (int i = 0; i < 6; i++) fcmds[i] = mk(1, 2, 16 + i, i % 5, 1);
    for (int i = 0; i < 32; i++) init_rf[i] = '0;
    init_rf[1] = 32'd5;
    init_rf[2] = 32'd7;

    // Reset state, while rst is high and on the first cycle after release.
    step();
    step();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rst%0d_ready", p), 64'(cmd_ready), 64'(1));
      chk($sformatf("rst%0d_busy", p), 64'(busy), 64'(0));
      chk($sformatf("rst%0d_qcount", p), 64'(q_count), 64'(0));
      chk($sformatf("rst%0d_strobes", p), 64'({dp_alu_en, dp_w_en, rsp_valid}), 64'(0));
      chk($sformatf("rst%0d_dp", p), 64'({dp_r_addr_a, dp_r_addr_b, dp_w_addr, dp_alu_op}),
          64'(0));
      chk($sformatf("rst%0d_rsp", p), 64'({rsp_res, rsp_flags}), 64'(0));
      rst = 1'b0;
      #1;
    end

    // Table-driven vectors, each run to completion before the next.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i].c, ta, tw, tr, wa, res, fl, bz);
      chk($sformatf("v%0d_res", i), 64'(res), 64'(vecs[i].res));
      chk($sformatf("v%0d_flags", i), 64'(fl), 64'(vecs[i].flags));
      chk($sformatf("v%0d_rsp_cycle", i), 64'(tr), 64'(5));
      chk($sformatf("v%0d_wen", i), 64'(tw > 0), 64'(vecs[i].wen));
      chk($sformatf("v%0d_busy_after", i), 64'(bz), 64'(0));
      if (i == 0) begin
        chk("v0_alu_cycle", 64'(ta), 64'(3));
        chk("v0_wen_cycle", 64'(tw), 64'(4));
        chk("v0_wen_addr", 64'(wa), 64'(3));
      end
    end

    // Dependent chain, second push while the first is in READ.
    do_reset();
    run_pair(mk(1, 2, 3, OpAdd, 1), mk(3, 1, 4, OpAdd, 1), 2, t0, t1, r0, r1, nw, nr, qc1, qc2);
    chk("chain_res0", 64'(r0), 64'(12));
    chk("chain_res1", 64'(r1), 64'(17));
    chk("chain_t0", 64'(t0), 64'(5));
    chk("chain_gap", 64'(t1 - t0), 64'(5));
    chk("chain_wen_count", 64'(nw), 64'(2));
    chk("chain_rsp_count", 64'(nr), 64'(2));

    // Push exactly in the IDLE pop cycle with one entry queued.
    do_reset();
    run_pair(mk(1, 2, 3, OpSub, 1), mk(3, 2, 4, OpAdd, 1), 1, t0, t1, r0, r1, nw, nr, qc1, qc2);
    chk("pp_qcount_c1", 64'(qc1), 64'(1));
    chk("pp_qcount_c2", 64'(qc2), 64'(1));
    chk("pp_res0", 64'(r0), 64'(32'hFFFF_FFFE));
    chk("pp_res1", 64'(r1), 64'(5));
    chk("pp_times", 64'({t0[7:0], t1[7:0]}), 64'({8'd5, 8'd10}));
    chk("pp_rsp_count", 64'(nr), 64'(2));

    // FIFO full: cmd_valid held across six back-to-back commands.
    do_reset();
    idx = 0; first_full = -1; ready_at_full = 1'b1; maxq = 0; base_r = rsp_seen;
    for (int k = 0; k < 80; k++) begin
      if (idx < 6) drive(fcmds[idx], 1'b1);
      else cmd_valid = 1'b0;
      if (q_count == 3'd4 && first_full < 0) begin first_full = k; ready_at_full = cmd_ready; end
      if (int'(q_count) > maxq) maxq = int'(q_count);
      if (idx < 6 && cmd_ready) idx++;
      step();
    end
    cmd_valid = 1'b0;
    chk("full_first_cycle", 64'(first_full), 64'(5));
    chk("full_ready_low", 64'(ready_at_full), 64'(0));
    chk("full_max_qcount", 64'(maxq), 64'(4));
    chk("full_accepted", 64'(idx), 64'(6));
    chk("full_rsp_count", 64'(rsp_seen - base_r), 64'(6));
    chk("full_drained", 64'({q_count, busy}), 64'(0));
    chk("full_scoreboard_empty", 64'(exp_q.size()), 64'(0));

    // Reset asserted during EXEC with two commands queued.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(mk(1, 2, 20 + k, OpAdd, 1), 1'b1);
      step();
    end
    cmd_valid = 1'b0;
    chk("abort_in_exec", 64'(dp_alu_en), 64'(1));
    chk("abort_queued", 64'(q_count), 64'(2));
    rst = 1'b1;
    #1;
    chk("abort_rst_strobe", 64'({dp_alu_en, dp_w_en, rsp_valid}), 64'(0));
    step();
    rst = 1'b0;
    #1;
    chk("abort_qcount", 64'(q_count), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_ready", 64'(cmd_ready), 64'(1));
    base_r = rsp_seen; base_w = wen_seen;
    for (int k = 0; k < 12; k++) step();
    chk("abort_no_rsp", 64'(rsp_seen - base_r), 64'(0));
    chk("abort_no_wen", 64'(wen_seen - base_w), 64'(0));

    // Randomized traffic over a small register window to force dependencies.
    for (int i = 1; i < 32; i++) init_rf[i] = $urandom;
    do_reset();
    base_r = rsp_seen;
    for (int k = 0; k < 600; k++) begin
      drive(mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 1))), $urandom_range(0, 2) != 0);
      step();
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 100 && busy; k++) step();
    chk("rand_drained", 64'({q_count, busy}), 64'(0));
    chk("rand_scoreboard_empty", 64'(exp_q.size()), 64'(0));
    chk("rand_enough_rsp", 64'((rsp_seen - base_r) >= 50), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/alu_reg_sequencer.md
Name: alu_reg_sequencer

Overview:
Single-issue command sequencer that drives the ALU-with-register-file datapath.
- Replaces manual switch and button stepping with one-cycle strobes.
- Accepts ALU commands (two source registers, destination, op, write-back flag) through a valid/ready port, buffered in a small FIFO.
- Runs each command through a fixed read/execute/write-back/respond sequence and returns result and flags.
- Sits between a command source (test harness or future decode stage) and the datapath; result also feeds the LED display.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, >= 2
- ADDR_W, 5, register address width
- OP_W, 4, ALU op code width
- DATA_W, 32, datapath result width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; high when count < DEPTH
- cmd_ra  in  ADDR_W  source A register
- cmd_rb  in  ADDR_W  source B register
- cmd_rd  in  ADDR_W  destination register
- cmd_op  in  OP_W  ALU operation
- cmd_wb  in  1  1 = write result back to cmd_rd
- dp_r_addr_a  out  ADDR_W  datapath read address A
- dp_r_addr_b  out  ADDR_W  datapath read address B
- dp_w_addr  out  ADDR_W  datapath write address
- dp_alu_op  out  OP_W  datapath ALU op
- dp_alu_en  out  1  one-cycle ALU result-latch strobe
- dp_w_en  out  1  one-cycle register write strobe
- dp_res  in  DATA_W  ALU result from datapath
- dp_flags  in  4  ALU flags from datapath
- rsp_valid  out  1  one-cycle response pulse
- rsp_res  out  DATA_W  captured result
- rsp_flags  out  4  captured flags
- busy  out  1  state != IDLE or FIFO non-empty
- q_count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Synchronous active-high reset. While rst is high and on the first cycle after it:
  - state = IDLE; FIFO pointers and count = 0
  - all dp_* outputs, rsp_valid, rsp_res, rsp_flags and busy = 0
  - cmd_ready = 1
- FIFO push: on cmd_valid && cmd_ready, the {ra, rb, rd, op, wb} tuple is written.
- FIFO pop: only in IDLE when count > 0.
- Push and pop in the same cycle leaves count unchanged. Pointers wrap modulo DEPTH.
- cmd_ready depends on count only; there is no combinational path from cmd_valid.
- FSM, registered, one state per cycle:
  - IDLE: if count > 0, pop the head into the current-command register and go to READ; else stay.
  - READ: dp_r_addr_a/b, dp_w_addr and dp_alu_op driven from the current command and held stable through DONE. Go to EXEC.
  - EXEC: dp_alu_en = 1 for this cycle only. Go to WB.
  - WB: dp_w_en = 1 only if wb == 1 and rd != 0; register 0 writes are suppressed. Capture dp_res into rsp_res and dp_flags into rsp_flags. Go to DONE.
  - DONE: rsp_valid = 1 for this cycle only. Go to IDLE.
- Timing: a push at cycle 0 into an empty, idle block gives IDLE pop at cycle 1, READ at 2, EXEC at 3, WB at 4, rsp_valid at 5. Sustained throughput is one command per 5 cycles.
- Between commands, dp_* addresses and op hold their last value; strobes are 0 outside their state.
- rsp_res and rsp_flags hold until the next WB.
- Commands execute strictly in FIFO order. Each command's reads see all earlier write-backs, because write-back completes before the next READ.
- The push port stays active during execution. A push while full is ignored, and cmd_ready is already low.
- Reset mid-operation aborts the current command: no write strobe, no response, FIFO flushed.

Decomposition:
- Shared include header holds:
  - FSM state encodings (IDLE, READ, EXEC, WB, DONE; 3 bits)
  - command-field bit offsets for the packed FIFO word of width 3*ADDR_W + OP_W + 1
- One sub-module, alu_cmd_fifo: synchronous FIFO with push/pop/count/full/empty, parameterised by DEPTH and word width.
- The FSM and strobe logic stay in the top.

Test Plan:
- Single command: reset, then push ra=1, rb=2, rd=3, op=ADD, wb=1 with the datapath model holding x1=5, x2=7. Required: dp_alu_en at cycle 3, dp_w_en at cycle 4 with dp_w_addr=3, rsp_valid at cycle 5 with rsp_res=12, busy=0 at cycle 6.
- Dependent chain: push (x3=x1+x2) then (x4=x3+x1). Required: second rsp_res=17, responses 5 cycles apart, exactly two dp_w_en pulses.
- rd=0 and wb=0: both commands produce rsp_valid with correct rsp_res and no dp_w_en pulse.
- FIFO full: hold cmd_valid with 6 back-to-back commands at DEPTH=4. Required: cmd_ready drops when q_count reaches 4, no command is lost or duplicated, responses come in push order, q_count returns to 0.
- Reset mid-command: assert rst during EXEC with 2 commands queued. Required: no dp_w_en or rsp_valid afterwards, q_count=0, busy=0, cmd_ready=1 on the cycle after reset.
- Simultaneous push/pop: push exactly in the IDLE pop cycle with count=1. Required: q_count stays 1, and both commands complete in order.
